// File: rtl/tri_vertex_ctrl.sv
// Debounced button editor for the three triangle vertices, with shadow registers committed at frame start.
// Latency: event appears 2+DB_CYCLES cycles after a stable press; shadow written one cycle later; outputs update on frame_start.
// Backpressure: none; events that arrive during an EDIT cycle or lose SEL>X>Y priority are dropped.
module tri_vertex_ctrl #(
    parameter int STEP      = 4,
    parameter int X_MIN     = 285,
    parameter int X_MAX     = 1554,
    parameter int Y_MIN     = 35,
    parameter int Y_MAX     = 514,
    parameter int DB_CYCLES = 1000000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               KEY_SEL_N,
    input  logic               KEY_X_N,
    input  logic               KEY_Y_N,
    input  logic               dir,
    input  logic               frame_start,
    output logic signed [25:0] p1_x,
    output logic signed [25:0] p1_y,
    output logic signed [25:0] p2_x,
    output logic signed [25:0] p2_y,
    output logic signed [25:0] p3_x,
    output logic signed [25:0] p3_y,
    output logic [1:0]         sel,
    output logic               pending
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    localparam logic signed [26:0] STEP27 = 27'(STEP);
    localparam logic signed [26:0] XLO27  = 27'(X_MIN);
    localparam logic signed [26:0] XHI27  = 27'(X_MAX);
    localparam logic signed [26:0] YLO27  = 27'(Y_MIN);
    localparam logic signed [26:0] YHI27  = 27'(Y_MAX);

    localparam logic signed [25:0] RST_X [3] = '{26'sd300, 26'sd400, 26'sd600};
    localparam logic signed [25:0] RST_Y [3] = '{26'sd100, 26'sd300, 26'sd200};

    typedef enum logic {S_IDLE, S_EDIT} state_t;

    typedef struct packed {
        logic       axis_y;
        logic [1:0] idx;
        logic       dn;
    } tgt_t;

    // Bit 0 = SEL, bit 1 = X, bit 2 = Y throughout.
    logic [2:0]    key_raw;
    logic [2:0]    sync1, sync2;
    logic [2:0]    db_lvl;
    logic [2:0]    evt;
    logic [CW-1:0] db_cnt [3];

    state_t state, state_nxt;
    logic   sel_adv, tgt_load, edit_wr;
    tgt_t   tgt;

    logic signed [25:0] sh_x [3];
    logic signed [25:0] sh_y [3];
    logic signed [25:0] o_x  [3];
    logic signed [25:0] o_y  [3];

    logic signed [25:0] cur;
    logic signed [26:0] ext, sum, lo27, hi27;
    logic signed [25:0] nxt;

    assign key_raw = {KEY_Y_N, KEY_X_N, KEY_SEL_N};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // An event fires in the first cycle the accepted level reads 0; releases are silent.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            db_lvl <= '1;
            evt    <= '0;
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                evt[k] <= 1'b0;
                if (sync2[k] != db_lvl[k]) begin
                    if (db_cnt[k] == CNT_MAX) begin
                        db_lvl[k] <= ~db_lvl[k];
                        db_cnt[k] <= '0;
                        evt[k]    <= db_lvl[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + CW'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel_adv   = 1'b0;
        tgt_load  = 1'b0;
        edit_wr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (evt[0]) begin
                    sel_adv = 1'b1;
                end else if (evt[1] || evt[2]) begin
                    tgt_load  = 1'b1;
                    state_nxt = S_EDIT;
                end
            end
            S_EDIT: begin
                edit_wr   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cur = '0;
        case (tgt.idx)
            2'd1:    cur = tgt.axis_y ? sh_y[1] : sh_x[1];
            2'd2:    cur = tgt.axis_y ? sh_y[2] : sh_x[2];
            default: cur = tgt.axis_y ? sh_y[0] : sh_x[0];
        endcase
    end

    // Step in 27 bits so the clamp sees the true result even near the 26-bit limits.
    always_comb begin
        ext  = {cur[25], cur};
        sum  = tgt.dn ? (ext - STEP27) : (ext + STEP27);
        lo27 = tgt.axis_y ? YLO27 : XLO27;
        hi27 = tgt.axis_y ? YHI27 : XHI27;
        if (sum < lo27)      nxt = lo27[25:0];
        else if (sum > hi27) nxt = hi27[25:0];
        else                 nxt = sum[25:0];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tgt     <= '0;
            sel     <= 2'd0;
            pending <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                sh_x[k] <= RST_X[k];
                sh_y[k] <= RST_Y[k];
                o_x[k]  <= RST_X[k];
                o_y[k]  <= RST_Y[k];
            end
        end else begin
            if (tgt_load) begin
                tgt.axis_y <= ~evt[1];
                tgt.idx    <= sel;
                tgt.dn     <= dir;
            end
            if (sel_adv) sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            // Commit reads the pre-edit shadows when it coincides with an EDIT write.
            if (frame_start && pending) begin
                for (int k = 0; k < 3; k++) begin
                    o_x[k] <= sh_x[k];
                    o_y[k] <= sh_y[k];
                end
            end
            if (edit_wr) begin
                for (int k = 0; k < 3; k++) begin
                    if (tgt.idx == 2'(k)) begin
                        if (tgt.axis_y) sh_y[k] <= nxt;
                        else            sh_x[k] <= nxt;
                    end
                end
            end
            if (edit_wr)          pending <= 1'b1;
            else if (frame_start) pending <= 1'b0;
        end
    end

    assign p1_x = o_x[0];
    assign p1_y = o_y[0];
    assign p2_x = o_x[1];
    assign p2_y = o_y[1];
    assign p3_x = o_x[2];
    assign p3_y = o_y[2];

endmodule

// File: doc/tri_vertex_ctrl.md
# tri_vertex_ctrl

Interactive controller for the three triangle vertex registers consumed by the VGA triangle renderer. It debounces three push-buttons and lets the user select a vertex and step it in X or Y. Edits go into shadow registers that are clamped to the visible window. Shadow values are committed to the renderer-facing vertex outputs only at the frame-start pulse from the VGA timing counter, so the triangle never tears mid-frame.

## Interface
Parameters:
- STEP, 4: coordinate increment per accepted press (counter units).
- X_MIN, 285: lowest allowed vertex X (first visible cx).
- X_MAX, 1554: highest allowed vertex X (last visible cx).
- Y_MIN, 35: lowest allowed vertex Y.
- Y_MAX, 514: highest allowed vertex Y.
- DB_CYCLES, 1000000: number of consecutive stable cycles required to accept a button level (20 ms at 50 MHz).

Ports:
- CLOCK_50, in, 1: single clock for all logic.
- RESET_N, in, 1: asynchronous, active-low reset (top level drives it from KEY[0]).
- KEY_SEL_N, in, 1: select-next-vertex button, active-low, asynchronous.
- KEY_X_N, in, 1: step-X button, active-low, asynchronous.
- KEY_Y_N, in, 1: step-Y button, active-low, asynchronous.
- dir, in, 1: step direction. 0 adds +STEP, 1 adds −STEP. Sampled in the event cycle.
- frame_start, in, 1: one-cycle pulse from the timing generator at cx==0 && cy==0.
- p1_x, p1_y, p2_x, p2_y, p3_x, p3_y, out, 26 signed each: committed vertex coordinates.
- sel, out, 2: currently selected vertex. Values are 0, 1 or 2 only.
- pending, out, 1: shadow registers differ from the outputs, and a commit is awaited.

## Operation
- **Synchronizer:** each KEY input passes through a 2-flop synchronizer.
- **Debouncer, per key:**
  - Holds an accepted level (reset 1) and a counter (reset 0).
  - While the synchronized level differs from the accepted level, the counter increments. Otherwise the counter clears.
  - When the counter reaches DB_CYCLES−1, the accepted level toggles and the counter clears.
  - An accepted 1→0 transition produces a one-cycle event. Releases produce no event.
- **Event priority:** if several events occur in one cycle, priority is SEL > X > Y. Lower-priority events in that cycle are dropped.
- **FSM states:** IDLE, EDIT.
  - IDLE + SEL event: sel advances 0→1→2→0. State stays IDLE. pending is unchanged.
  - IDLE + X or Y event: latch the target (axis, sel, dir). Go to EDIT.
  - EDIT: compute the new shadow coordinate in 27-bit signed arithmetic as shadow ± STEP. Clamp the result into [MIN, MAX] for the axis. Write the shadow, set pending=1, return to IDLE.
  - Any event arriving while in EDIT is dropped.
- **Commit:**
  - On a frame_start cycle with pending=1, all six shadow registers are copied to the outputs and pending clears.
  - On frame_start with pending=0, nothing changes.
- **Simultaneous commit and EDIT write:** if frame_start coincides with an EDIT write, the commit copies the pre-edit shadows. pending stays 1, so the edit appears at the next frame.
- **Clamp boundaries:** stepping at the bound leaves the value unchanged but still sets pending=1. A result exactly on the bound is accepted as-is.
- **Reset values:**
  - Outputs and shadows: p1=(300,100), p2=(400,300), p3=(600,200).
  - sel=0, pending=0, FSM=IDLE.
  - Debounce levels 1, counters 0, synchronizer flops 1.
- **Reset mid-operation:** an asserted RESET_N forces all reset values immediately. A pending edit or an EDIT in flight is discarded.

## Timing
- **Press to event:** a press held stable produces its event 2 (sync) + DB_CYCLES cycles after the input edge.
- **Event to shadow:** the shadow is written at the end of the cycle after the event (EDIT cycle). pending is high from the following cycle.
- **sel update:** sel updates in the cycle after the SEL event.
- **Commit latency:** outputs update on the clock edge that samples frame_start=1. New values are visible from the next cycle, and stay constant for the whole frame.
- **Output changes:** outputs change only on a commit or on reset.

## Test plan
Run all scenarios with DB_CYCLES=4.
1. **Reset:** release reset → p1..p3 = (300,100), (400,300), (600,200); sel=0; pending=0.
2. **X step and commit:** press KEY_X_N, dir=0, sel=0 → shadow p1_x=304 and pending=1. Outputs stay at 300 until a frame_start pulse, then p1_x=304 and pending=0.
3. **Select cycling:** 4 SEL presses → sel sequence 1, 2, 0, 1. A Y press with dir=1 then a commit → p2_y=296.
4. **Clamp:** with sel=2, repeat Y presses (dir=0) until p3_y reaches 514. Three further presses plus a commit → p3_y=514, and pending clears after the commit.
5. **Bounce rejection and event collision:**
   - X input toggling every 2 cycles for 40 cycles → no event, no shadow change.
   - Simultaneous SEL and X accepted presses → only sel changes.
6. **Commit race and reset mid-edit:**
   - frame_start in the same cycle as the EDIT write → outputs keep old values, pending=1. The next frame_start commits the edit.
   - Assert RESET_N during EDIT → reset values restored, no edit applied.
